// File: rtl/gray_rx_decoder.sv
// Receives an asynchronous Gray count, synchronises it, decodes it to binary and checks single forward steps.
// Optional: define STEP_ERR_COUNT_EN to add the saturating err_count output.
module gray_rx_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 wrap,
    output logic                 step_err,
    output logic                 err_sticky,
`ifdef STEP_ERR_COUNT_EN
    output logic [ERR_CNT_W-1:0] err_count,
`endif
    output logic                 locked
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [2:0]       FILL_LAST = 3'(SYNC_STAGES);
    localparam logic [WIDTH-1:0] BIN_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] BIN_ONES  = {WIDTH{1'b1}};

    // Elaboration-time guard on the parameter ranges the design supports
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || ERR_CNT_W < 1 || WIDTH < 2) begin : g_bad_param
            $error("gray_rx_decoder: unsupported parameter value");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] dec_s;
    logic [WIDTH-1:0] prev_r;
    logic [2:0]       fill_r;
    logic             changed_s;
    logic             legal_s;
    logic             bad_s;
    logic             was_ones_s;
    state_t           state_r;

    // Multi-flop synchroniser; only the last stage is used by the decoder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Decode and step classification of the synchronised sample
    always_comb begin
        g_s        = sync_r[SYNC_STAGES-1];
        dec_s      = gray_to_bin(g_s);
        changed_s  = 1'b0;
        legal_s    = 1'b0;
        bad_s      = 1'b0;
        was_ones_s = 1'b0;
        if (g_s != prev_r) begin
            changed_s = 1'b1;
            legal_s   = (dec_s == (bin_out + BIN_ONE));
            bad_s     = (dec_s != (bin_out + BIN_ONE));
        end else begin
            changed_s = 1'b0;
        end
        if (bin_out == BIN_ONES) begin
            was_ones_s = 1'b1;
        end else begin
            was_ones_s = 1'b0;
        end
    end

    // Lock/track/error state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            fill_r     <= 3'd0;
            prev_r     <= {WIDTH{1'b0}};
            bin_out    <= {WIDTH{1'b0}};
            bin_valid  <= 1'b0;
            wrap       <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            locked     <= 1'b0;
`ifdef STEP_ERR_COUNT_EN
            err_count  <= {ERR_CNT_W{1'b0}};
`endif
        end else begin
            bin_valid <= 1'b0;
            wrap      <= 1'b0;
            step_err  <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    // Wait for the synchroniser to fill, then adopt the value unchecked
                    if (fill_r == FILL_LAST) begin
                        prev_r  <= g_s;
                        bin_out <= dec_s;
                        locked  <= 1'b1;
                        state_r <= ST_TRACK;
                    end else begin
                        fill_r <= fill_r + 3'd1;
                    end
                end
                ST_TRACK, ST_ERROR: begin
                    if (changed_s) begin
                        prev_r  <= g_s;
                        bin_out <= dec_s;
                    end
                    if (legal_s) begin
                        bin_valid <= 1'b1;
                        wrap      <= was_ones_s;
                    end
                    // A new error outranks a coincident clear request
                    if (bad_s) begin
                        step_err   <= 1'b1;
                        err_sticky <= 1'b1;
                        locked     <= 1'b0;
                        state_r    <= ST_ERROR;
`ifdef STEP_ERR_COUNT_EN
                        if (err_count != {ERR_CNT_W{1'b1}}) begin
                            err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                        end
`endif
                    end else if (err_clr && (state_r == ST_ERROR)) begin
                        err_sticky <= 1'b0;
                        locked     <= 1'b1;
                        state_r    <= ST_TRACK;
`ifdef STEP_ERR_COUNT_EN
                        err_count  <= {ERR_CNT_W{1'b0}};
`endif
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    fill_r     <= 3'd0;
                    locked     <= 1'b0;
                    err_sticky <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Self-checking bench for gray_rx_decoder: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_gray_rx_decoder;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] gray_in;
    logic         err_clr;
    logic [W-1:0] bin_out;
    logic         bin_valid;
    logic         wrap;
    logic         step_err;
    logic         err_sticky;
    logic         locked;
`ifdef STEP_ERR_COUNT_EN
    logic [CW-1:0] err_count;
`endif

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_wrap   = 0;
    int n_err    = 0;

    gray_rx_decoder #(.WIDTH(W), .SYNC_STAGES(S), .ERR_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .err_clr    (err_clr),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .wrap       (wrap),
        .step_err   (step_err),
        .err_sticky (err_sticky),
`ifdef STEP_ERR_COUNT_EN
        .err_count  (err_count),
`endif
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Gray code of v is v ^ (v >> 1); decoding searches for the matching binary value
    function automatic int g2b(input int g);
        for (int v = 0; v < (1 << W); v++) begin
            if ((v ^ (v >> 1)) == g) return v;
        end
        return -1;
    endfunction

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    // Behavioural model state
    int q[$];
    int m_edges, m_bin, m_cnt;
    bit m_started, m_sticky, m_valid, m_wrap, m_err;

    always @(posedge clk or negedge rst_n) begin : model
        int gs, nb;
        bit v_valid, v_wrap, v_err;
        if (!rst_n) begin
            q.delete();
            m_edges   <= 0;
            m_bin     <= 0;
            m_cnt     <= 0;
            m_started <= 1'b0;
            m_sticky  <= 1'b0;
            m_valid   <= 1'b0;
            m_wrap    <= 1'b0;
            m_err     <= 1'b0;
        end else begin
            gs = (q.size() >= S) ? q[q.size() - S] : 0;
            q.push_back(int'(gray_in));
            if (q.size() > S) void'(q.pop_front());
            v_valid = 1'b0;
            v_wrap  = 1'b0;
            v_err   = 1'b0;
            if (!m_started) begin
                if (m_edges == S) begin
                    m_bin     <= g2b(gs);
                    m_started <= 1'b1;
                end else begin
                    m_edges <= m_edges + 1;
                end
            end else begin
                if (gs != b2g(m_bin)) begin
                    nb = g2b(gs);
                    if (nb == ((m_bin + 1) % (1 << W))) begin
                        v_valid = 1'b1;
                        v_wrap  = (m_bin == (1 << W) - 1);
                    end else begin
                        v_err = 1'b1;
                    end
                    m_bin <= nb;
                end
                if (v_err) begin
                    m_sticky <= 1'b1;
                    m_cnt    <= (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
                end else if (err_clr && m_sticky) begin
                    m_sticky <= 1'b0;
                    m_cnt    <= 0;
                end
            end
            m_valid <= v_valid;
            m_wrap  <= v_wrap;
            m_err   <= v_err;
        end
    end

    // Per-cycle comparison against the model, plus pulse tallies
    always @(negedge clk) begin
        if (rst_n) begin
            check("bin_out",    int'(bin_out),    m_bin);
            check("bin_valid",  int'(bin_valid),  int'(m_valid));
            check("wrap",       int'(wrap),       int'(m_wrap));
            check("step_err",   int'(step_err),   int'(m_err));
            check("err_sticky", int'(err_sticky), int'(m_sticky));
            check("locked",     int'(locked),     int'(m_started && !m_sticky));
`ifdef STEP_ERR_COUNT_EN
            check("err_count",  int'(err_count),  m_cnt);
`endif
            if (bin_valid) n_valid <= n_valid + 1;
            if (wrap)      n_wrap  <= n_wrap + 1;
            if (step_err)  n_err   <= n_err + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic step(input logic [W-1:0] g);
        gray_in = g;
        cyc(4);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    logic [W-1:0] gt [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin : stim
        int v0, w0, e0;
        rst_n   = 1'b0;
        err_clr = 1'b0;
        gray_in = 4'b0000;
        #3;
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_locked",  int'(locked),  0);
        check("rst_valid",   int'(bin_valid), 0);
        check("rst_sticky",  int'(err_sticky), 0);
        cyc(1);
        rst_n = 1'b1;

        // Lock after the third edge
        cyc(1);
        check("lock_e1", int'(locked), 0);
        cyc(1);
        check("lock_e2", int'(locked), 0);
        cyc(1);
        check("lock_e3", int'(locked), 1);
        check("lock_bin", int'(bin_out), 0);
        check("lock_no_valid", n_valid, 0);
        check("lock_no_err", n_err, 0);

        // Full count with wrap
        v0 = n_valid; w0 = n_wrap; e0 = n_err;
        for (int i = 1; i <= 16; i++) begin
            step(gt[i % 16]);
            check("count_bin", int'(bin_out), i % 16);
        end
        check("count_valids", n_valid - v0, 16);
        check("count_wraps",  n_wrap - w0, 1);
        check("count_errs",   n_err - e0, 0);

        // Skip from 2 to 4, then legal step while unlocked
        step(gt[1]);
        step(gt[2]);
        e0 = n_err;
        step(4'b0110);
        check("skip_err", n_err - e0, 1);
        check("skip_bin", int'(bin_out), 4);
        check("skip_sticky", int'(err_sticky), 1);
        check("skip_locked", int'(locked), 0);
        v0 = n_valid;
        step(4'b0111);
        check("after_skip_valid", n_valid - v0, 1);
        check("after_skip_bin", int'(bin_out), 5);
        check("after_skip_locked", int'(locked), 0);

        // err_clr alone re-locks
        pulse_clr();
        check("clr_locked", int'(locked), 1);
        check("clr_sticky", int'(err_sticky), 0);
        cyc(1);

        // err_clr colliding with a backward step 0101 -> 0111
        step(4'b1111);
        check("err2_locked", int'(locked), 0);
        step(4'b0101);
        gray_in = 4'b0111;
        cyc(2);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("coll_step_err", int'(step_err), 1);
        check("coll_sticky", int'(err_sticky), 1);
        check("coll_locked", int'(locked), 0);
        check("coll_bin", int'(bin_out), 5);
        cyc(1);
        check("coll_locked_hold", int'(locked), 0);
        pulse_clr();
        check("clr2_locked", int'(locked), 1);
        step(gt[6]);
        check("relock_bin", int'(bin_out), 6);

        // Reset mid-run at bin 1001, release with gray_in = 1101
        step(gt[7]);
        step(gt[8]);
        step(gt[9]);
        check("pre_rst_bin", int'(bin_out), 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_bin", int'(bin_out), 0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_sticky", int'(err_sticky), 0);
        cyc(2);
        rst_n = 1'b1;
        v0 = n_valid;
        cyc(2);
        check("rel_e2_locked", int'(locked), 0);
        cyc(1);
        check("rel_e3_locked", int'(locked), 1);
        check("rel_bin", int'(bin_out), 9);
        check("rel_no_valid", n_valid - v0, 0);

`ifdef STEP_ERR_COUNT_EN
        // 300 illegal changes saturate the counter
        for (int i = 0; i < 300; i++) begin
            gray_in = (i % 2 == 0) ? 4'b0011 : 4'b0000;
            cyc(1);
        end
        cyc(4);
        check("sat_count", int'(err_count), 255);
        check("sat_locked", int'(locked), 0);
        pulse_clr();
        check("sat_clr_count", int'(err_count), 0);
        check("sat_clr_locked", int'(locked), 1);
`endif
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_rx_decoder.md
Name: gray_rx_decoder

Overview:
Downstream consumer of the 4-bit Gray counter stage. It synchronises a Gray count that arrives from another (or unrelated) clock domain and decodes it to binary. It checks that each observed change is exactly one forward count step, and reports new values, wrap-around and step errors to local logic. It sits at the receiving end of any Gray-coded pointer or counter crossing into the clk domain.

Parameters:
WIDTH, 4, bit width of Gray input and binary output
SYNC_STAGES, 2, flip-flop stages in input synchroniser (legal range 2..4)
ERR_CNT_W, 8, width of error counter (optional feature only)

Ports:
clk  input  1  sole clock
rst_n  input  1  asynchronous active-low reset
gray_in  input  WIDTH  Gray count from upstream counter, treated as asynchronous
err_clr  input  1  single-cycle request to clear sticky error and re-lock
bin_out  output  WIDTH  decoded binary of last accepted sample
bin_valid  output  1  one-cycle pulse: bin_out updated by a legal step
wrap  output  1  one-cycle pulse: legal step from all-ones to zero
step_err  output  1  one-cycle pulse: illegal change detected
err_sticky  output  1  set on any step error, held until err_clr
locked  output  1  high in TRACK state
err_count  output  ERR_CNT_W  saturating error count (only with STEP_ERR_COUNT_EN)

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, prev-sample register, bin_out = 0; bin_valid, wrap, step_err, err_sticky, locked = 0; fill counter = 0; state = INIT; err_count = 0.
- Synchroniser: gray_in passes through SYNC_STAGES flops. g_s is the last stage.
- Decode is combinational from g_s: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. Output is registered into bin_out.
- State machine: INIT, TRACK, ERROR.
- INIT: counts SYNC_STAGES edges after reset release. On the next edge it loads prev and bin_out from g_s without any check and without a bin_valid pulse, then moves to TRACK. locked rises on that same edge.
- TRACK/ERROR: if g_s == prev, nothing happens and all pulses are 0.
- On a change with decode(g_s) == bin_out + 1 mod 2^WIDTH (legal):
  - update bin_out and prev
  - pulse bin_valid
  - pulse wrap if old bin_out was all-ones
- On any other change (multi-bit flip, backward step, skip):
  - update bin_out and prev (resynchronise to the new value)
  - pulse step_err; no bin_valid
  - set err_sticky; go to ERROR, so locked = 0
- ERROR state: tracks and checks identically. err_clr clears err_sticky and returns to TRACK on the next edge.
- err_clr in the same cycle as a new illegal change: the error wins; err_sticky stays set and state stays ERROR.
- err_clr in TRACK or INIT: ignored.
- Latency: a gray_in change that is stable before edge 1 appears on bin_out/bin_valid after edge SYNC_STAGES+1.
- Pulses are registered and last exactly one cycle. Consecutive legal steps on consecutive cycles give back-to-back pulses.
- rst_n asserted mid-operation: immediate return to the reset values; re-lock follows the full INIT sequence.

Optional Feature:
STEP_ERR_COUNT_EN
- Defined: err_count port exists. It increments on every step_err pulse and saturates at all-ones. err_clr zeroes it on the same edge it clears err_sticky; on a simultaneous error the count increments and is not zeroed.
- Undefined: port and counter are absent; all other behaviour is unchanged.

Test Plan:
- Reset/lock: gray_in=0000, release rst_n → locked=1 exactly after edge 3 (SYNC_STAGES=2); bin_out=0000; no bin_valid/step_err pulses.
- Full count: drive Gray sequence 0000,0001,0011,…,1000,0000, one step per 4 clocks → 16 bin_valid pulses, bin_out 1..15 then 0; wrap pulse only on 15→0; step_err never.
- Skip: from bin 2 (gray 0011) drive 0110 (bin 4) → step_err pulse, bin_out=0100, err_sticky=1, locked=0; next legal step 0111 → bin_valid, bin_out=0101, still unlocked.
- Clear/collision: in ERROR pulse err_clr alone → locked=1, err_sticky=0. Repeat with err_clr coinciding with backward step 0101→0111 → err_sticky stays 1, locked stays 0.
- Reset mid-run: assert rst_n low at bin_out=1001 → outputs 0 immediately; release with gray_in=1101 → locked after 3 edges, bin_out=1001, no bin_valid.
- STEP_ERR_COUNT_EN: 300 illegal changes → err_count saturates at 255; err_clr → 0.
